and_chain_ctrl: RTL
===================

# and_chain_ctrl

Sequencing controller for the cascaded-AND datapath used in the lab designs. It accepts N-bit operands from two requesters through valid/ready handshakes and arbitrates between them round-robin. It evaluates the partial-AND chain x, y, z, … one stage per clock on a single shared 2-input AND step, then returns all N-1 partial products with the requester's ID. It sits between the switch/button input logic and the LED output register.

## Interface
- N, 4: operand width in bits (N ≥ 2); result width is N-1
- clk  input  1  system clock; all state updates on the rising edge
- rst_n  input  1  reset; asynchronous, active-low
- req0_valid  input  1  requester 0 has an operand
- req0_data  input  N  requester 0 operand
- req0_ready  output  1  requester 0 operand accepted this cycle
- req1_valid  input  1  requester 1 has an operand
- req1_data  input  N  requester 1 operand
- req1_ready  output  1  requester 1 operand accepted this cycle
- res_valid  output  1  result available
- res_ready  input  1  consumer takes result
- res_part  output  N-1  partial ANDs: bit k = &op[k+1:0] (bit0 = x, bit1 = y, bit2 = z for N=4)
- res_id  output  1  requester that supplied the operand
- busy  output  1  state ≠ IDLE

## Operation
- FSM states: IDLE, EVAL, DONE.
- IDLE → EVAL on handshake (reqX_valid & reqX_ready).
- EVAL → DONE after N-1 EVAL cycles.
- DONE → IDLE on res_valid & res_ready.
- Grant is combinational and computed only in IDLE:
  - grant0 = req0_valid & (!req1_valid | last == 1)
  - grant1 = req1_valid & (!req0_valid | last == 0)
  - reqX_ready = (state == IDLE) & grantX.
  - ready is 0 in EVAL and DONE.
- On handshake:
  - op ← reqX_data; res_id ← X; last ← X.
  - acc (drives res_part) ← 0; step counter ← 1.
- EVAL step k (k = 1..N-1): acc[k-1] ← (k == 1 ? op[0] : acc[k-2]) & op[k].
- Exactly one AND per cycle, through the shared step unit.
- Counter increments each EVAL cycle; the transition to DONE happens on the edge that writes acc[N-2].
- DONE:
  - res_valid = 1.
  - res_part and res_id are held stable until res_ready is sampled high.
- Requesters hold valid and data stable until ready. Data is sampled only at the handshake edge.
- A lone requester is always granted; round-robin only breaks ties.
- res_part is meaningful only while res_valid. During EVAL it shows the partial accumulation, with unwritten bits 0.

## Timing
- Reset values: state IDLE, last = 1 (req0 wins first tie), acc = 0, res_id = 0, res_valid = 0, busy = 0, req0_ready = req1_ready = 0 unless a valid input is present in IDLE.
- Reset mid-operation aborts immediately. No result is produced and the operand is lost.
- Latency: handshake at edge t puts res_valid high after edge t+N-1 (3 cycles for N=4).
- res_valid drops after the consuming edge. The next handshake can occur on the following cycle, at the earliest.
- Throughput: at most one operation per N+1 cycles.
- Simultaneous arrival is resolved by the last pointer. A valid asserted during EVAL/DONE waits for IDLE.
- res_ready high before DONE has no effect.

## Structure
- Shared header and_chain_defs.vh:
  - state encodings IDLE = 2'd0, EVAL = 2'd1, DONE = 2'd2
  - default N
  - counter width = clog2(N)
- Sub-module rr_arb2: 2-way round-robin arbiter.
  - Inputs: valid0, valid1, last, enable.
  - Outputs: grant0, grant1.
  - Purely combinational; the last register stays in and_chain_ctrl.

## Test plan
All with N=4, res_ready = 1 unless stated.
- req0 alone, data 4'b1111 → req0_ready for 1 cycle; res_valid 3 cycles later; res_part 3'b111, res_id 0.
- req0 data 4'b1011 → res_part 3'b001 (x=1, y=0, z=0); mid-EVAL res_part shows 3'b001 then stays.
- After reset both valid, req0 4'b0111, req1 4'b1110 → req0 served first (res_part 3'b011, id 0), then req1 (res_part 3'b000, id 1); next tie goes to req0.
- Backpressure: res_ready low 5 cycles in DONE → res_valid, res_part, res_id stable; busy = 1; both readys 0; drops the cycle after res_ready rises.
- Reset asserted during EVAL step 2 → all outputs 0 asynchronously; after release the first tie is granted to req0.
- req1 alone, 3 back-to-back operands → each accepted, one handshake every 5 cycles; res_id 1 each time.

Source files
------------

// File: rtl/and_chain_ctrl_pkg.sv
// and_chain_ctrl_pkg: shared state encodings, default width and counter sizing
package and_chain_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_N = 4;

    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/and_chain_ctrl_if.sv
// and_chain_ctrl_if: requester handshakes and result channel of the AND-chain controller
interface and_chain_ctrl_if
    import and_chain_ctrl_pkg::*;
#(
    parameter int N = DEF_N
);
    logic         req0_valid;
    logic [N-1:0] req0_data;
    logic         req0_ready;
    logic         req1_valid;
    logic [N-1:0] req1_data;
    logic         req1_ready;
    logic         res_valid;
    logic         res_ready;
    logic [N-2:0] res_part;
    logic         res_id;

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, res_ready,
        input  req0_ready, req1_ready, res_valid, res_part, res_id
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, res_ready,
        output req0_ready, req1_ready, res_valid, res_part, res_id
    );
endinterface

// File: rtl/and_chain_ctrl_rr_arb2.sv
// rr_arb2: two-way round-robin grant; a lone requester always wins, ties go away from last
module rr_arb2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last,
    input  logic enable,
    output logic grant0,
    output logic grant1
);
    assign grant0 = enable & valid0 & (!valid1 | last);
    assign grant1 = enable & valid1 & (!valid0 | !last);
endmodule

// File: rtl/and_chain_ctrl.sv
// and_chain_ctrl: arbitrates two operand sources and evaluates the partial-AND chain one stage per clock
module and_chain_ctrl
    import and_chain_ctrl_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic             clk,
    input  logic             rst_n,
    and_chain_ctrl_if.slave  bus,
    output logic             busy
);
    localparam int CW = cnt_w(N);

    state_t        state;
    logic          last;
    logic [N-1:0]  op;
    logic [N-2:0]  acc;
    logic [CW-1:0] cnt;
    logic          res_id;
    logic          res_valid;
    logic          g0;
    logic          g1;
    logic          a;
    logic          b;
    logic          step;

    rr_arb2 u_arb (
        .valid0 (bus.req0_valid),
        .valid1 (bus.req1_valid),
        .last   (last),
        .enable (state == IDLE),
        .grant0 (g0),
        .grant1 (g1)
    );

    assign bus.req0_ready = g0;
    assign bus.req1_ready = g1;
    assign bus.res_valid  = res_valid;
    assign bus.res_part   = acc;
    assign bus.res_id     = res_id;

    // Shared step unit: stage 1 ANDs op[0] with op[1], later stages extend the previous partial
    always_comb begin
        a = op[0];
        b = op[1];
        for (int k = 2; k < N; k++)
            if (cnt == CW'(k)) begin
                a = acc[k-2];
                b = op[k];
            end
    end

    assign step = a & b;

    // Controller FSM: capture on grant, one chain stage per EVAL cycle, hold result until consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last      <= 1'b1;
            op        <= '0;
            acc       <= '0;
            cnt       <= '0;
            res_id    <= 1'b0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (g0 || g1) begin
                    op     <= g0 ? bus.req0_data : bus.req1_data;
                    res_id <= g1;
                    last   <= g1;
                    acc    <= '0;
                    cnt    <= CW'(1);
                    busy   <= 1'b1;
                    state  <= EVAL;
                end
                EVAL: begin
                    for (int k = 1; k < N; k++)
                        if (cnt == CW'(k)) acc[k-1] <= step;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(N-1)) begin
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: if (bus.res_ready) begin
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
